// File: rtl/debug_controller_pkg.sv
// -----------------------------------------------------------------------------
// debug_controller_pkg
// Shared definitions for the pipeline debug controller and its transmit
// sequencer. It holds the default command bytes, the default dump length and
// the state encodings of both state machines.
// No ports (package).
// -----------------------------------------------------------------------------
package debug_controller_pkg;

    // Number of bytes in one state dump (legal range 2..255)
    localparam int DUMP_BYTES = 32;

    // Command bytes received from the UART: 's' single step, 'c' continue
    localparam logic [7:0] CMD_STEP_DEFAULT = 8'h73;
    localparam logic [7:0] CMD_CONT_DEFAULT = 8'h63;

    // Top-level sequencing. CTRL_DUMP covers the whole time the transmit
    // sequencer is busy (its SEND, WAIT_TX and DONE states).
    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_STEP,
        CTRL_CONT,
        CTRL_DUMP
    } ctrl_state_t;

    // Transmit sequencer states
    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_SEND,
        SEQ_WAIT_TX,
        SEQ_DONE
    } seq_state_t;

endpackage

// File: rtl/debug_controller_tx_sequencer.sv
// -----------------------------------------------------------------------------
// debug_tx_sequencer
// Walks through DATA_BYTES bytes of datapath state and hands each one to the
// UART transmitter. For every byte it spends one SEND cycle presenting the
// index to the datapath mux and latching the selected byte. It then waits in
// WAIT_TX for the transmitter to acknowledge. A one-cycle DONE state closes
// the dump and clears the counter.
// Ports:
//   clock, resetGral     system clock / asynchronous active-low reset
//   i_start              one-cycle request to begin a dump (ignored when busy)
//   i_txDone             transmitter finished the current byte
//   i_dumpByte           datapath byte selected by o_dumpIndex
//   o_txStart            one-cycle strobe, first cycle of WAIT_TX
//   o_txData             latched byte, held until the next SEND
//   o_dumpIndex          index requested from the datapath mux
//   o_sendCounter        bytes acknowledged so far in this dump
//   o_done               high for the single DONE cycle
// -----------------------------------------------------------------------------
module debug_tx_sequencer
    import debug_controller_pkg::*;
#(
    parameter int DATA_BYTES = DUMP_BYTES
) (
    input  logic       clock,
    input  logic       resetGral,
    input  logic       i_start,
    input  logic       i_txDone,
    input  logic [7:0] i_dumpByte,
    output logic       o_txStart,
    output logic [7:0] o_txData,
    output logic [7:0] o_dumpIndex,
    output logic [7:0] o_sendCounter,
    output logic       o_done
);

    localparam logic [7:0] LAST_INDEX = 8'(DATA_BYTES - 1);

    seq_state_t r_state;
    seq_state_t w_nextState;
    logic [7:0] r_sendCounter;
    logic [7:0] r_txData;
    logic       r_txStart;

    // State register
    always_ff @(posedge clock or negedge resetGral) begin
        if (!resetGral) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state. The counter is compared before it is incremented, so it
    // stops at LAST_INDEX and never wraps.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            SEQ_IDLE: begin
                if (i_start) begin
                    w_nextState = SEQ_SEND;
                end
            end
            SEQ_SEND: begin
                w_nextState = SEQ_WAIT_TX;
            end
            SEQ_WAIT_TX: begin
                if (i_txDone) begin
                    if (r_sendCounter == LAST_INDEX) begin
                        w_nextState = SEQ_DONE;
                    end else begin
                        w_nextState = SEQ_SEND;
                    end
                end
            end
            SEQ_DONE: begin
                w_nextState = SEQ_IDLE;
            end
            default: begin
                w_nextState = SEQ_IDLE;
            end
        endcase
    end

    // Datapath registers. txStart is registered off SEND, so it rises exactly
    // as WAIT_TX is entered and lasts one cycle. txData is captured on the
    // SEND cycle, when dumpIndex already points at the wanted byte.
    always_ff @(posedge clock or negedge resetGral) begin
        if (!resetGral) begin
            r_sendCounter <= 8'd0;
            r_txData      <= 8'd0;
            r_txStart     <= 1'b0;
        end else begin
            r_txStart <= (r_state == SEQ_SEND);
            if (r_state == SEQ_SEND) begin
                r_txData <= i_dumpByte;
            end
            if (r_state == SEQ_WAIT_TX && i_txDone && r_sendCounter != LAST_INDEX) begin
                r_sendCounter <= r_sendCounter + 8'd1;
            end else if (r_state == SEQ_DONE) begin
                r_sendCounter <= 8'd0;
            end
        end
    end

    assign o_txStart     = r_txStart;
    assign o_txData      = r_txData;
    assign o_dumpIndex   = r_sendCounter;
    assign o_sendCounter = r_sendCounter;
    assign o_done        = (r_state == SEQ_DONE);

endmodule

// File: rtl/debug_controller.sv
// -----------------------------------------------------------------------------
// debug_controller
// Debug unit sequencer for the pipelined datapath. It decodes command bytes
// from the UART receiver. A step command opens the pipeline enable for one
// cycle. A continue command keeps it open until the datapath halts. After
// either run it dumps DATA_BYTES bytes of state through the UART transmitter.
// Ports:
//   clock, resetGral     system clock / asynchronous active-low reset
//   rxDone, rxData       received byte strobe and value
//   txDone               UART TX finished the current byte
//   txStart, txData      start strobe and byte for UART TX
//   dumpIndex, dumpByte  datapath dump mux select and its selected byte
//   haltDetected         datapath reached its halt instruction
//   pipeEnable           pipeline register enable
//   ledIdle/Step/Cont/Send  one-hot state indicators
//   sendCounter          bytes acknowledged in the current dump
//   sentFlag             one-cycle pulse when a dump completes
// -----------------------------------------------------------------------------
module debug_controller
    import debug_controller_pkg::*;
#(
    parameter int         DATA_BYTES = DUMP_BYTES,
    parameter logic [7:0] CMD_STEP   = CMD_STEP_DEFAULT,
    parameter logic [7:0] CMD_CONT   = CMD_CONT_DEFAULT
) (
    input  logic       clock,
    input  logic       resetGral,
    input  logic       rxDone,
    input  logic [7:0] rxData,
    input  logic       txDone,
    output logic       txStart,
    output logic [7:0] txData,
    output logic [7:0] dumpIndex,
    input  logic [7:0] dumpByte,
    input  logic       haltDetected,
    output logic       pipeEnable,
    output logic       ledIdle,
    output logic       ledStep,
    output logic       ledCont,
    output logic       ledSend,
    output logic [7:0] sendCounter,
    output logic       sentFlag
);

    ctrl_state_t r_state;
    ctrl_state_t w_nextState;
    logic        w_seqStart;
    logic        w_seqDone;

    // State register
    always_ff @(posedge clock or negedge resetGral) begin
        if (!resetGral) begin
            r_state <= CTRL_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and sequencer kick-off. The sequencer is started on the same
    // edge that moves us into CTRL_DUMP, so its SEND cycle immediately follows
    // the run. Commands arriving outside IDLE are dropped.
    always_comb begin
        w_nextState = r_state;
        w_seqStart  = 1'b0;
        case (r_state)
            CTRL_IDLE: begin
                if (rxDone) begin
                    if (rxData == CMD_STEP) begin
                        w_nextState = CTRL_STEP;
                    end else if (rxData == CMD_CONT) begin
                        w_nextState = CTRL_CONT;
                    end
                end
            end
            CTRL_STEP: begin
                w_nextState = CTRL_DUMP;
                w_seqStart  = 1'b1;
            end
            CTRL_CONT: begin
                if (haltDetected) begin
                    w_nextState = CTRL_DUMP;
                    w_seqStart  = 1'b1;
                end
            end
            CTRL_DUMP: begin
                if (w_seqDone) begin
                    w_nextState = CTRL_IDLE;
                end
            end
            default: begin
                w_nextState = CTRL_IDLE;
            end
        endcase
    end

    debug_tx_sequencer #(
        .DATA_BYTES (DATA_BYTES)
    ) u_txSequencer (
        .clock         (clock),
        .resetGral     (resetGral),
        .i_start       (w_seqStart),
        .i_txDone      (txDone),
        .i_dumpByte    (dumpByte),
        .o_txStart     (txStart),
        .o_txData      (txData),
        .o_dumpIndex   (dumpIndex),
        .o_sendCounter (sendCounter),
        .o_done        (w_seqDone)
    );

    // In CONT the enable is gated by halt directly, so a datapath that is
    // already halted on entry advances zero cycles.
    assign pipeEnable = (r_state == CTRL_STEP) ||
                        ((r_state == CTRL_CONT) && !haltDetected);
    assign sentFlag   = w_seqDone;

    assign ledIdle = (r_state == CTRL_IDLE);
    assign ledStep = (r_state == CTRL_STEP);
    assign ledCont = (r_state == CTRL_CONT);
    assign ledSend = (r_state == CTRL_DUMP);

endmodule

// File: tb/tb_debug_controller.sv
// -----------------------------------------------------------------------------
// tb_debug_controller
// Directed bench for debug_controller. Each dump's expected bytes are queued
// when the command is issued. A monitor pops one entry per txStart pulse. A
// responder answers every txStart with txDone ten cycles later.
// -----------------------------------------------------------------------------
module tb_debug_controller;

    localparam int DATA_BYTES = 32;

    typedef struct {
        logic [7:0] data;
        logic [7:0] idx;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetGral;
    logic       rxDone;
    logic [7:0] rxData;
    logic       txDone;
    logic       txStart;
    logic [7:0] txData;
    logic [7:0] dumpIndex;
    logic [7:0] dumpByte;
    logic       haltDetected;
    logic       pipeEnable;
    logic       ledIdle;
    logic       ledStep;
    logic       ledCont;
    logic       ledSend;
    logic [7:0] sendCounter;
    logic       sentFlag;

    logic [7:0] salt;
    exp_t       expQ[$];
    int         checks = 0;
    int         errors = 0;
    int         pipeCount = 0;
    int         sentCount = 0;
    int         txStartCount = 0;

    always #5 clock = ~clock;

    debug_controller #(
        .DATA_BYTES (DATA_BYTES),
        .CMD_STEP   (8'h73),
        .CMD_CONT   (8'h63)
    ) dut (
        .clock        (clock),
        .resetGral    (resetGral),
        .rxDone       (rxDone),
        .rxData       (rxData),
        .txDone       (txDone),
        .txStart      (txStart),
        .txData       (txData),
        .dumpIndex    (dumpIndex),
        .dumpByte     (dumpByte),
        .haltDetected (haltDetected),
        .pipeEnable   (pipeEnable),
        .ledIdle      (ledIdle),
        .ledStep      (ledStep),
        .ledCont      (ledCont),
        .ledSend      (ledSend),
        .sendCounter  (sendCounter),
        .sentFlag     (sentFlag)
    );

    // Datapath byte for a given index. A per-dump salt distinguishes dumps.
    function automatic logic [7:0] dumpModel(input logic [7:0] idx, input logic [7:0] s);
        return 8'(idx * 8'd13) ^ s;
    endfunction

    assign dumpByte = dumpModel(dumpIndex, salt);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] cmd);
        @(negedge clock);
        rxData = cmd;
        rxDone = 1'b1;
        @(negedge clock);
        rxDone = 1'b0;
    endtask

    task automatic pushDump();
        exp_t e;
        for (int i = 0; i < DATA_BYTES; i++) begin
            e.data = dumpModel(8'(i), salt);
            e.idx  = 8'(i);
            expQ.push_back(e);
        end
    endtask

    // Wait (bounded) for the next completed dump, then check the DONE and
    // following IDLE cycles.
    task automatic waitDumpDone(input int startSent, input string name);
        int n;
        n = 0;
        while (sentCount == startSent && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checkOutput({name, "_completed"}, sentCount, startSent + 1);
        checkOutput({name, "_sentFlagHigh"}, {31'd0, sentFlag}, 1);
        @(negedge clock);
        checkOutput({name, "_ledIdleAfter"}, {31'd0, ledIdle}, 1);
        checkOutput({name, "_counterCleared"}, {24'd0, sendCounter}, 0);
        checkOutput({name, "_sentFlagLow"}, {31'd0, sentFlag}, 0);
        checkOutput({name, "_queueDrained"}, expQ.size(), 0);
    endtask

    // Monitor: samples one time unit after each rising edge
    initial begin
        logic prevTxStart;
        exp_t e;
        prevTxStart = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (pipeEnable) pipeCount++;
            if (sentFlag) sentCount++;
            if (txStart) begin
                txStartCount++;
                checkOutput("txStartOneCycle", {31'd0, prevTxStart}, 0);
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedTxStart: got txData %0h, expected no transfer", txData);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("txData", {24'd0, txData}, {24'd0, e.data});
                    checkOutput("sendCounter", {24'd0, sendCounter}, {24'd0, e.idx});
                end
            end
            prevTxStart = txStart;
        end
    end

    // UART TX model: acknowledge each byte ten cycles after txStart, unless a
    // reset intervened.
    initial begin
        logic aborted;
        txDone = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (txStart) begin
                aborted = 1'b0;
                repeat (10) begin
                    @(negedge clock);
                    if (!resetGral) aborted = 1'b1;
                end
                if (!aborted && resetGral) begin
                    txDone = 1'b1;
                    @(negedge clock);
                    txDone = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pipeBase;
        int txBase;
        int sentBase;
        int n;

        resetGral    = 1'b0;
        rxDone       = 1'b0;
        rxData       = 8'h00;
        haltDetected = 1'b0;
        salt         = 8'h5A;

        // Reset, then a quiet idle period
        repeat (3) @(negedge clock);
        checkOutput("rst_ledIdle", {31'd0, ledIdle}, 1);
        checkOutput("rst_otherLeds", {29'd0, ledStep, ledCont, ledSend}, 0);
        checkOutput("rst_pipeEnable", {31'd0, pipeEnable}, 0);
        checkOutput("rst_sendCounter", {24'd0, sendCounter}, 0);
        checkOutput("rst_txData", {24'd0, txData}, 0);
        checkOutput("rst_txStart", {31'd0, txStart}, 0);
        resetGral = 1'b1;
        repeat (100) @(negedge clock);
        checkOutput("idle_noTxStart", txStartCount, 0);
        checkOutput("idle_noPipe", pipeCount, 0);
        checkOutput("idle_ledIdle", {31'd0, ledIdle}, 1);

        // Unknown command is ignored
        $display("[TB] ignored command 0x41");
        applyStimulus(8'h41);
        checkOutput("ign_ledIdle", {31'd0, ledIdle}, 1);
        repeat (20) @(negedge clock);
        checkOutput("ign_noPipe", pipeCount, 0);
        checkOutput("ign_noTxStart", txStartCount, 0);
        checkOutput("ign_ledIdleLater", {31'd0, ledIdle}, 1);

        // Single step, with a second step command arriving during WAIT_TX
        $display("[TB] step");
        salt = 8'h11;
        pushDump();
        pipeBase = pipeCount;
        txBase   = txStartCount;
        sentBase = sentCount;
        applyStimulus(8'h73);
        checkOutput("step_pipeOn", {31'd0, pipeEnable}, 1);
        checkOutput("step_ledStep", {31'd0, ledStep}, 1);
        @(negedge clock);
        checkOutput("step_pipeOff", {31'd0, pipeEnable}, 0);
        checkOutput("step_ledSend", {31'd0, ledSend}, 1);
        n = 0;
        while (txStartCount < txBase + 3 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checkOutput("step_thirdByteSeen", txStartCount - txBase, 3);
        applyStimulus(8'h73);
        waitDumpDone(sentBase, "step");
        checkOutput("step_pipeCycles", pipeCount - pipeBase, 1);
        repeat (100) @(negedge clock);
        checkOutput("step_byteCount", txStartCount - txBase, DATA_BYTES);
        checkOutput("step_oneDump", sentCount - sentBase, 1);
        checkOutput("step_noExtraPipe", pipeCount - pipeBase, 1);

        // Continuous run, halt raised after 50 enabled cycles
        $display("[TB] continuous");
        salt = 8'h3C;
        pushDump();
        pipeBase = pipeCount;
        sentBase = sentCount;
        applyStimulus(8'h63);
        checkOutput("cont_ledCont", {31'd0, ledCont}, 1);
        checkOutput("cont_pipeOn", {31'd0, pipeEnable}, 1);
        repeat (49) @(negedge clock);
        haltDetected = 1'b1;
        waitDumpDone(sentBase, "cont");
        haltDetected = 1'b0;
        checkOutput("cont_pipeCycles", pipeCount - pipeBase, 50);

        // Halt already asserted when the continue command arrives
        $display("[TB] halt on entry");
        haltDetected = 1'b1;
        salt = 8'hA5;
        pushDump();
        pipeBase = pipeCount;
        sentBase = sentCount;
        applyStimulus(8'h63);
        checkOutput("hoe_ledCont", {31'd0, ledCont}, 1);
        checkOutput("hoe_pipeOff", {31'd0, pipeEnable}, 0);
        @(negedge clock);
        checkOutput("hoe_dumpStarted", {31'd0, ledSend}, 1);
        waitDumpDone(sentBase, "hoe");
        haltDetected = 1'b0;
        checkOutput("hoe_pipeCycles", pipeCount - pipeBase, 0);

        // Reset in the middle of a dump, then restart
        $display("[TB] reset mid-dump");
        salt = 8'h77;
        pushDump();
        sentBase = sentCount;
        applyStimulus(8'h73);
        n = 0;
        while (!(txStart && dumpIndex == 8'd5) && n < 500) begin
            @(negedge clock);
            n++;
        end
        checkOutput("mid_reachedByte5", {24'd0, dumpIndex}, 5);
        #1;
        resetGral = 1'b0;
        #1;
        checkOutput("mid_txStartDropped", {31'd0, txStart}, 0);
        checkOutput("mid_counterCleared", {24'd0, sendCounter}, 0);
        checkOutput("mid_ledIdle", {31'd0, ledIdle}, 1);
        checkOutput("mid_ledSend", {31'd0, ledSend}, 0);
        expQ.delete();
        repeat (4) @(negedge clock);
        resetGral = 1'b1;
        repeat (12) @(negedge clock);
        checkOutput("mid_noDumpCompleted", sentCount - sentBase, 0);
        salt = 8'hC3;
        pushDump();
        sentBase = sentCount;
        applyStimulus(8'h73);
        waitDumpDone(sentBase, "restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
